codificador_sequencia: RTL and testbench
========================================

// Module: codificador_sequencia
// PURPOSE
//  Transmit-side counterpart of Decodificador: turns a target request into the legal 7-bit
//  codeword stream the decoder accepts. Walks C1..Cn through adjacent states, then sends the
//  terminator (C6 for n=1..3, C8 for n=4..5). Invalid targets send C7 once.
//  Sits between the control logic and Decodificador.Entrada/Controle.
// PARAMETERS
//  HOLD_CYCLES  4  clk cycles each codeword is held on Saida (>=1)
// PORTS
//  clk       in   1  system clock, rising edge
//  Reset     in   1  asynchronous, active-high; returns block to OCIOSO
//  Inicio    in   1  start request, sampled on clk; honoured only when Ocupado=0
//  Destino   in   3  target state n; 1..5 legal, 0/6/7 invalid
//  Saida     out  7  codeword to decoder Entrada; 7'b0000000 when idle
//  Controle  out  1  high while Saida carries a codeword
//  Ocupado   out  1  high from accepted Inicio until the Fim cycle, inclusive
//  Fim       out  1  one-cycle pulse: sequence complete
//  Erro      out  1  one-cycle pulse coincident with Fim when Destino was invalid
// BEHAVIOUR
//  Codewords: C1=1100000 C2=1000100 C3=1111100 C4=1011010 C5=1101110
//             C6=1001001 C7=1110101 C8=1010011
//  Reset (async): state=OCIOSO, Saida=0, Controle=0, Ocupado=0, Fim=0, Erro=0, counters=0.
//  All outputs are registered.
//  FSM states: OCIOSO, ENVIA_ESTADO, ENVIA_FINAL, ENVIA_INVALIDO, CONCLUI.
//  OCIOSO + Inicio: latch Destino into alvo.
//   - alvo in 1..5 -> ENVIA_ESTADO, idx=1.
//   - otherwise -> ENVIA_INVALIDO.
//   - First codeword visible on Saida after the same edge that samples Inicio (latency 1 edge).
//  ENVIA_ESTADO: Saida=C[idx] for HOLD_CYCLES cycles.
//   - At hold end: idx<alvo -> idx+1; idx==alvo -> ENVIA_FINAL.
//  ENVIA_FINAL: Saida = C6 (alvo<=3) or C8 (alvo>=4), held HOLD_CYCLES, then CONCLUI.
//  ENVIA_INVALIDO: Saida=C7 for HOLD_CYCLES, then CONCLUI.
//  CONCLUI: lasts exactly 1 cycle.
//   - Saida=0, Controle=0, Fim=1, Ocupado=1.
//   - Erro=1 iff the invalid path was taken.
//   - Next state: OCIOSO.
//  Hold counter: 0..HOLD_CYCLES-1; wraps to 0 at every codeword change.
//   - No gap cycles between consecutive codewords.
//  Total Ocupado length = (alvo+1)*HOLD_CYCLES+1 (valid) or HOLD_CYCLES+1 (invalid).
//  Inicio while Ocupado=1: ignored; Destino changes mid-sequence: ignored (alvo is latched).
//  Inicio in the CONCLUI cycle: ignored; a new start is accepted from OCIOSO only.
//  Reset mid-sequence: outputs drop to reset values immediately; no Fim is produced.
//  Controle = 1 exactly in ENVIA_* states.
//  Saida never carries a non-adjacent state step.
// STRUCTURE
//  Shared package decodificador_pkg (also used by Decodificador):
//   - localparams C1..C8 (7 bits each);
//   - FSM state encoding;
//   - localparam DESTINO_MAX=5.
//  One sub-module: contador_retencao (parameter HOLD_CYCLES; inputs clk, Reset, clear;
//   output fim_ret high on the last hold cycle).
//  Codeword selection is a combinational mux from idx/state in the top module.
// TESTING (HOLD_CYCLES=4; bench also chains Saida/Controle into Decodificador)
//  1. Reset=1 mid-cycle, no clk edge -> Saida=0000000, Ocupado=0 immediately.
//  2. Destino=1, Inicio pulse -> C1 x4, C6 x4, Fim at cycle 9, Erro=0;
//     decoder Saida=0001 (output 1).
//  3. Destino=5 -> C1,C2,C3,C4,C5 x4 each, then C8 x4; Ocupado 25 cycles;
//     decoder Saida=0010 (output 2).
//  4. Destino=6 -> C7 x4; Fim and Erro together at cycle 5; decoder reports invalid.
//  5. Destino=3, Inicio re-pulsed with Destino=1 during C2 -> re-pulse ignored;
//     sequence C1,C2,C3,C6 completes unchanged.
//  6. Destino=4, Reset during C3 -> Saida=0 at once, no Fim;
//     next Inicio with Destino=2 -> C1,C2,C6 correct.

Source files
------------

// File: rtl/decodificador_pkg.sv
// Shared definitions for the codeword link between the sequence encoder and
// Decodificador: the eight 7-bit codewords, the highest legal target state and
// the encoder FSM state encoding.
package decodificador_pkg;

  // Codewords as seen on the decoder Entrada bus
  localparam logic [6:0] C1 = 7'b1100000;
  localparam logic [6:0] C2 = 7'b1000100;
  localparam logic [6:0] C3 = 7'b1111100;
  localparam logic [6:0] C4 = 7'b1011010;
  localparam logic [6:0] C5 = 7'b1101110;
  localparam logic [6:0] C6 = 7'b1001001;
  localparam logic [6:0] C7 = 7'b1110101;
  localparam logic [6:0] C8 = 7'b1010011;

  // Highest target state; 1..DESTINO_MAX are legal targets
  localparam logic [2:0] DESTINO_MAX = 3'd5;

  typedef enum logic [2:0] {
    OCIOSO,
    ENVIA_ESTADO,
    ENVIA_FINAL,
    ENVIA_INVALIDO,
    CONCLUI
  } estado_e;

  // True when the target can be reached by walking C1..Cn
  function automatic logic destino_valido(input logic [2:0] d);
    return (d >= 3'd1) && (d <= DESTINO_MAX);
  endfunction

endpackage

// File: rtl/contador_retencao.sv
// Hold counter: counts the cycles a codeword has been on the bus.
// Ports:
//   clk     - system clock, rising edge
//   Reset   - asynchronous, active-high, clears the count
//   clear   - synchronous restart at 0 on the next edge
//   fim_ret - high during the last hold cycle (count == HOLD_CYCLES-1)
module contador_retencao #(
  parameter int HOLD_CYCLES = 4
) (
  input  logic clk,
  input  logic Reset,
  input  logic clear,
  output logic fim_ret
);

  // A single-cycle hold still needs a 1-bit counter to keep widths legal
  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: restart on clear, otherwise step; the owner clears on the
  // last hold cycle so the count never runs past HOLD_CYCLES-1
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Count register
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign fim_ret = (cnt_q == CW'(HOLD_CYCLES - 1));

endmodule

// File: rtl/codificador_sequencia.sv
// Sequence encoder: turns a target request into the codeword stream accepted by
// Decodificador. Walks C1..Cn, then sends C6 (n<=3) or C8 (n>=4); an invalid
// target sends C7 once. Each codeword is held HOLD_CYCLES cycles.
// Ports:
//   clk      - system clock, rising edge
//   Reset    - asynchronous, active-high; returns to OCIOSO
//   Inicio   - start request, honoured only while idle
//   Destino  - target state n (1..5 legal)
//   Saida    - codeword to the decoder, zero when idle
//   Controle - high while Saida carries a codeword
//   Ocupado  - high from accepted Inicio through the Fim cycle
//   Fim      - one-cycle completion pulse
//   Erro     - pulses with Fim when the target was invalid
module codificador_sequencia
  import decodificador_pkg::*;
#(
  parameter int HOLD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       Reset,
  input  logic       Inicio,
  input  logic [2:0] Destino,
  output logic [6:0] Saida,
  output logic       Controle,
  output logic       Ocupado,
  output logic       Fim,
  output logic       Erro
);

  estado_e    state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [2:0] alvo_q, alvo_d;

  logic [6:0] saida_q, saida_d;
  logic       controle_q, controle_d;
  logic       ocupado_q, ocupado_d;
  logic       fim_q, fim_d;
  logic       erro_q, erro_d;

  logic       enviando;
  logic       fim_ret;
  logic       clear_ret;

  assign enviando = (state_q == ENVIA_ESTADO) || (state_q == ENVIA_FINAL) ||
                    (state_q == ENVIA_INVALIDO);

  // The hold count restarts whenever a codeword ends and stays parked at 0
  // outside the sending states, so every new codeword starts from a fresh count
  assign clear_ret = !enviando || fim_ret;

  contador_retencao #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_contador (
    .clk    (clk),
    .Reset  (Reset),
    .clear  (clear_ret),
    .fim_ret(fim_ret)
  );

  // Next-state logic: the target is latched once at start, so later changes
  // on Destino or extra Inicio pulses cannot disturb a running sequence
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    alvo_d  = alvo_q;
    unique case (state_q)
      OCIOSO: begin
        if (Inicio) begin
          alvo_d = Destino;
          if (destino_valido(Destino)) begin
            state_d = ENVIA_ESTADO;
            idx_d   = 3'd1;
          end else begin
            state_d = ENVIA_INVALIDO;
          end
        end
      end
      ENVIA_ESTADO: begin
        if (fim_ret) begin
          if (idx_q < alvo_q) begin
            idx_d = idx_q + 3'd1;
          end else begin
            state_d = ENVIA_FINAL;
          end
        end
      end
      ENVIA_FINAL, ENVIA_INVALIDO: begin
        if (fim_ret) begin
          state_d = CONCLUI;
        end
      end
      CONCLUI: begin
        state_d = OCIOSO;
      end
      default: begin
        state_d = OCIOSO;
      end
    endcase
  end

  // Output decode from the next state so every output is registered yet the
  // first codeword appears right after the edge that accepts Inicio
  always_comb begin
    saida_d    = '0;
    controle_d = 1'b0;
    ocupado_d  = (state_d != OCIOSO);
    fim_d      = (state_d == CONCLUI);
    erro_d     = (state_d == CONCLUI) && (state_q == ENVIA_INVALIDO);
    unique case (state_d)
      ENVIA_ESTADO: begin
        controle_d = 1'b1;
        unique case (idx_d)
          3'd1:    saida_d = C1;
          3'd2:    saida_d = C2;
          3'd3:    saida_d = C3;
          3'd4:    saida_d = C4;
          3'd5:    saida_d = C5;
          default: saida_d = '0;
        endcase
      end
      ENVIA_FINAL: begin
        controle_d = 1'b1;
        saida_d    = (alvo_d <= 3'd3) ? C6 : C8;
      end
      ENVIA_INVALIDO: begin
        controle_d = 1'b1;
        saida_d    = C7;
      end
      default: begin
        saida_d = '0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= OCIOSO;
      idx_q      <= '0;
      alvo_q     <= '0;
      saida_q    <= '0;
      controle_q <= 1'b0;
      ocupado_q  <= 1'b0;
      fim_q      <= 1'b0;
      erro_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      alvo_q     <= alvo_d;
      saida_q    <= saida_d;
      controle_q <= controle_d;
      ocupado_q  <= ocupado_d;
      fim_q      <= fim_d;
      erro_q     <= erro_d;
    end
  end

  assign Saida    = saida_q;
  assign Controle = controle_q;
  assign Ocupado  = ocupado_q;
  assign Fim      = fim_q;
  assign Erro     = erro_q;

endmodule

// File: tb/tb_codificador_sequencia.sv
// Scoreboard bench for codificador_sequencia with HOLD_CYCLES=4.
module tb_codificador_sequencia;

  localparam logic [6:0] W1 = 7'b1100000;
  localparam logic [6:0] W2 = 7'b1000100;
  localparam logic [6:0] W3 = 7'b1111100;
  localparam logic [6:0] W4 = 7'b1011010;
  localparam logic [6:0] W5 = 7'b1101110;
  localparam logic [6:0] W6 = 7'b1001001;
  localparam logic [6:0] W7 = 7'b1110101;
  localparam logic [6:0] W8 = 7'b1010011;

  typedef struct packed {
    logic [6:0] saida;
    logic       ctrl;
    logic       fim;
    logic       erro;
  } exp_t;

  logic       clk;
  logic       Reset;
  logic       Inicio;
  logic [2:0] Destino;
  logic [6:0] Saida;
  logic       Controle;
  logic       Ocupado;
  logic       Fim;
  logic       Erro;

  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;

  codificador_sequencia #(
    .HOLD_CYCLES(4)
  ) dut (
    .clk     (clk),
    .Reset   (Reset),
    .Inicio  (Inicio),
    .Destino (Destino),
    .Saida   (Saida),
    .Controle(Controle),
    .Ocupado (Ocupado),
    .Fim     (Fim),
    .Erro    (Erro)
  );

  // Clock: 10 time units, rising edges at 5, 15, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Monitor: every busy cycle consumes one expected entry; idle cycles must be quiet
  always @(negedge clk) begin
    exp_t act;
    exp_t e;
    act = '{saida: Saida, ctrl: Controle, fim: Fim, erro: Erro};
    if (!Reset) begin
      checks++;
      if (Ocupado) begin
        if (expQ.size() == 0) begin
          errors++;
          $display("[TB] FAIL busy_extra: got ocupado=1 saida=%b, expected ocupado=0", Saida);
        end else begin
          e = expQ.pop_front();
          if (act !== e) begin
            errors++;
            $display("[TB] FAIL stream: got saida=%b ctrl=%b fim=%b erro=%b, expected saida=%b ctrl=%b fim=%b erro=%b",
                     act.saida, act.ctrl, act.fim, act.erro, e.saida, e.ctrl, e.fim, e.erro);
          end
        end
      end else if (act !== exp_t'(0)) begin
        errors++;
        $display("[TB] FAIL idle: got saida=%b ctrl=%b fim=%b erro=%b, expected all zero",
                 act.saida, act.ctrl, act.fim, act.erro);
      end
    end
  end

  // Issue a start and push the hand-computed stream: each word x4, then the Fim cycle
  task automatic applyStimulus(input logic [2:0] d, input logic [41:0] words,
                               input int n, input logic erro);
    @(posedge clk);
    #1;
    Inicio  = 1'b1;
    Destino = d;
    for (int k = 0; k < n; k++) begin
      for (int h = 0; h < 4; h++) begin
        expQ.push_back('{saida: words[k*7 +: 7], ctrl: 1'b1, fim: 1'b0, erro: 1'b0});
      end
    end
    expQ.push_back('{saida: 7'b0, ctrl: 1'b0, fim: 1'b1, erro: erro});
    @(posedge clk);
    #1;
    Inicio  = 1'b0;
    Destino = 3'd7;
  endtask

  // Wait for the stream to drain and the block to go idle, bounded
  task automatic waitDone(input string name);
    int k;
    k = 0;
    while ((expQ.size() != 0 || Ocupado) && k < 100) begin
      @(posedge clk);
      k++;
    end
    #1;
    checks++;
    if (k >= 100) begin
      errors++;
      $display("[TB] FAIL %s_done: got %0d entries pending ocupado=%b, expected 0 pending ocupado=0",
               name, expQ.size(), Ocupado);
      expQ.delete();
    end
    repeat (2) @(posedge clk);
  endtask

  // Direct comparison of the outputs at this instant
  task automatic checkOutput(input string name, input logic [6:0] s, input logic c,
                             input logic o, input logic f, input logic e);
    checks++;
    if ({Saida, Controle, Ocupado, Fim, Erro} !== {s, c, o, f, e}) begin
      errors++;
      $display("[TB] FAIL %s: got saida=%b ctrl=%b ocup=%b fim=%b erro=%b, expected saida=%b ctrl=%b ocup=%b fim=%b erro=%b",
               name, Saida, Controle, Ocupado, Fim, Erro, s, c, o, f, e);
    end
  endtask

  initial begin
    Reset   = 1'b0;
    Inicio  = 1'b0;
    Destino = 3'd0;

    // Asynchronous reset before any clock edge
    #2 Reset = 1'b1;
    #1 checkOutput("reset_async", 7'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1 Reset = 1'b0;
    repeat (2) @(posedge clk);

    // Shortest legal target
    applyStimulus(3'd1, 42'({W6, W1}), 2, 1'b0);
    waitDone("dest1");

    // Longest legal target
    applyStimulus(3'd5, 42'({W8, W5, W4, W3, W2, W1}), 6, 1'b0);
    waitDone("dest5");

    // Invalid targets
    applyStimulus(3'd6, 42'(W7), 1, 1'b1);
    waitDone("dest6");
    applyStimulus(3'd0, 42'(W7), 1, 1'b1);
    waitDone("dest0");
    applyStimulus(3'd7, 42'(W7), 1, 1'b1);
    waitDone("dest7");

    // Terminator boundary: 4 is the first target ending in C8
    applyStimulus(3'd4, 42'({W8, W4, W3, W2, W1}), 5, 1'b0);
    waitDone("dest4");

    // Re-pulse during C2 must be ignored
    applyStimulus(3'd3, 42'({W6, W3, W2, W1}), 4, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    Inicio  = 1'b1;
    Destino = 3'd1;
    @(posedge clk);
    #1 Inicio = 1'b0;
    waitDone("repulse");

    // Reset during C3 of a target-4 sequence, then a clean target-2 run
    applyStimulus(3'd4, 42'({W8, W4, W3, W2, W1}), 5, 1'b0);
    repeat (8) @(posedge clk);
    #2;
    checkOutput("before_reset_c3", W3, 1'b1, 1'b1, 1'b0, 1'b0);
    Reset = 1'b1;
    #1 checkOutput("reset_mid", 7'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    expQ.delete();
    repeat (2) @(posedge clk);
    #1 Reset = 1'b0;
    repeat (3) @(posedge clk);
    applyStimulus(3'd2, 42'({W6, W2, W1}), 3, 1'b0);
    waitDone("after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
